// File: rtl/aibcr3aux_osc_clksel_ctrl.sv
// rtl/aibcr3aux_osc_clksel_ctrl.sv - aux oscillator clock-mux select sequencer
//
// Drives the select of the aux oscillator clock mux. The mux input ina is the
// always-on reference clock (the clock this block runs on). The mux input inb
// is the local ring oscillator. A request enables the oscillator, waits out a
// warm-up interval, then moves sel to inb. Every sel change is followed by a
// settle hold. On the way back, the oscillator is disabled only after sel has
// returned to ina.
//
// Ports:
//   clk           always-on reference clock (same clock as mux ina)
//   rst           synchronous active-high reset
//   vcc_aibcraux  supply, no logic function
//   vss_aibcraux  ground, no logic function
//   req_b         level request, 1 = run from the oscillator (inb)
//   osc_en        ring-oscillator enable
//   sel           mux select, 0 = ina, 1 = inb
//   busy          high in transitional states
//   cur_b         high only in steady state ON_B
//   done          one-cycle pulse when a switch completes

module aibcr3aux_osc_clksel_ctrl #(
    parameter int CNT_W      = 8,
    parameter int WARM_CYC   = 16,
    parameter int SETTLE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    inout  wire  vcc_aibcraux,
    inout  wire  vss_aibcraux,
    input  logic req_b,
    output logic osc_en,
    output logic sel,
    output logic busy,
    output logic cur_b,
    output logic done
);

    typedef enum logic [2:0] {
        IDLE_A   = 3'd0,
        WARM     = 3'd1,
        SWITCH_B = 3'd2,
        ON_B     = 3'd3,
        SWITCH_A = 3'd4
    } state_t;

    // A state of interval N is left when the count reaches N-1.
    localparam logic [CNT_W-1:0] WARM_LAST   = CNT_W'(WARM_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       out_q;

    // Supply pins carry no logic; the reduction keeps them visibly consumed.
    wire unused_supply = vcc_aibcraux ^ vss_aibcraux;

    // {osc_en, sel, busy, cur_b} for each state.
    function automatic logic [3:0] outs(input state_t st);
        case (st)
            WARM:     outs = 4'b1010;
            SWITCH_B: outs = 4'b1110;
            ON_B:     outs = 4'b1101;
            SWITCH_A: outs = 4'b1010;
            default:  outs = 4'b0000;
        endcase
    endfunction

    // Outputs are loaded together with the state, so every output is a flop
    // and req_b never reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE_A;
            cnt   <= '0;
            out_q <= outs(IDLE_A);
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE_A: begin
                    if (req_b) begin
                        state <= WARM;
                        cnt   <= '0;
                        out_q <= outs(WARM);
                    end
                end
                WARM: begin
                    if (!req_b) begin
                        // Abort: sel never moved, so no completion pulse.
                        state <= IDLE_A;
                        cnt   <= '0;
                        out_q <= outs(IDLE_A);
                    end else if (cnt == WARM_LAST) begin
                        state <= SWITCH_B;
                        cnt   <= '0;
                        out_q <= outs(SWITCH_B);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SWITCH_B: begin
                    // Not abortable; a dropped request is seen from ON_B.
                    if (cnt == SETTLE_LAST) begin
                        state <= ON_B;
                        cnt   <= '0;
                        out_q <= outs(ON_B);
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ON_B: begin
                    if (!req_b) begin
                        state <= SWITCH_A;
                        cnt   <= '0;
                        out_q <= outs(SWITCH_A);
                    end
                end
                SWITCH_A: begin
                    // Oscillator stays enabled until sel has settled on ina.
                    if (cnt == SETTLE_LAST) begin
                        state <= IDLE_A;
                        cnt   <= '0;
                        out_q <= outs(IDLE_A);
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE_A;
                    cnt   <= '0;
                    out_q <= outs(IDLE_A);
                end
            endcase
        end
    end

    assign osc_en = out_q[3];
    assign sel    = out_q[2];
    assign busy   = out_q[1];
    assign cur_b  = out_q[0];

endmodule

// File: tb/tb_aibcr3aux_osc_clksel_ctrl.sv
// tb/tb_aibcr3aux_osc_clksel_ctrl.sv - directed self-checking bench for aibcr3aux_osc_clksel_ctrl

module tb_aibcr3aux_osc_clksel_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic req_b;
    logic osc_en;
    logic sel;
    logic busy;
    logic cur_b;
    logic done;
    wire  vcc = 1'b1;
    wire  vss = 1'b0;

    int errors = 0;
    int checks = 0;

    // Observed vector order: {osc_en, sel, busy, cur_b, done}
    localparam logic [4:0] V_IDLE   = 5'b00000;
    localparam logic [4:0] V_WARM   = 5'b10100;
    localparam logic [4:0] V_SWB    = 5'b11100;
    localparam logic [4:0] V_ONB_D  = 5'b11011;
    localparam logic [4:0] V_ONB    = 5'b11010;
    localparam logic [4:0] V_SWA    = 5'b10100;
    localparam logic [4:0] V_IDLE_D = 5'b00001;

    aibcr3aux_osc_clksel_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .vcc_aibcraux (vcc),
        .vss_aibcraux (vss),
        .req_b        (req_b),
        .osc_en       (osc_en),
        .sel          (sel),
        .busy         (busy),
        .cur_b        (cur_b),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Advance one active edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int edge_no, input logic [4:0] exp_v);
        logic [4:0] obs;
        obs = {osc_en, sel, busy, cur_b, done};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $display("FAIL %s edge %0d: observed %b expected %b", tag, edge_no, obs, exp_v);
            $error("check %s edge %0d observed %b expected %b", tag, edge_no, obs, exp_v);
        end
    endtask

    // Hand-derived forward timeline with WARM_CYC=16, SETTLE_CYC=4.
    function automatic logic [4:0] fwd_exp(input int e);
        if (e <= 15)      fwd_exp = V_WARM;
        else if (e <= 19) fwd_exp = V_SWB;
        else if (e == 20) fwd_exp = V_ONB_D;
        else              fwd_exp = V_ONB;
    endfunction

    // req_b must already be 1; checks edges 0..last.
    task automatic run_forward(input string tag, input int last);
        for (int e = 0; e <= last; e++) begin
            step();
            check(tag, e, fwd_exp(e));
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req_b = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        req_b = 1'b0;
        #1;

        // Reset then idle
        do_reset();
        check("reset", -1, V_IDLE);
        for (int i = 0; i < 50; i++) begin
            step();
            check("idle_hold", i, V_IDLE);
        end

        // Forward switch
        req_b = 1'b1;
        run_forward("forward", 22);

        // Reverse switch from ON_B
        req_b = 1'b0;
        for (int e = 0; e <= 5; e++) begin
            step();
            if (e <= 3)      check("reverse", e, V_SWA);
            else if (e == 4) check("reverse", e, V_IDLE_D);
            else             check("reverse", e, V_IDLE);
        end

        // Warm abort: high at edge 0, low at edge 5
        req_b = 1'b1;
        run_forward("abort_warm", 4);
        req_b = 1'b0;
        for (int e = 5; e <= 25; e++) begin
            step();
            check("abort", e, V_IDLE);
        end

        // Deferred request: drop during SWITCH_B at edge 18
        req_b = 1'b1;
        run_forward("defer_fwd", 17);
        req_b = 1'b0;
        for (int e = 18; e <= 27; e++) begin
            step();
            if (e <= 19)      check("defer", e, V_SWB);
            else if (e == 20) check("defer", e, V_ONB_D);
            else if (e <= 24) check("defer", e, V_SWA);
            else if (e == 25) check("defer", e, V_IDLE_D);
            else              check("defer", e, V_IDLE);
        end

        // Reset mid-sequence at edge 18, then full replay
        req_b = 1'b1;
        run_forward("midrst_fwd", 17);
        rst = 1'b1;
        step();
        check("midrst", 18, V_IDLE);
        rst = 1'b0;
        run_forward("replay", 21);

        // Return to idle
        req_b = 1'b0;
        repeat (4) step();
        step();
        check("final_idle", 4, V_IDLE_D);
        step();
        check("final_idle", 5, V_IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
